rx_serial_8n1: RTL



---
 rtl/rx_serial_8n1.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rx_serial_8n1.sv
// rx_serial_8n1: 8N1 asynchronous serial receiver, LSB first, mid-bit sampling.
// Define RX_SYNC2_EN to put a two-flop synchronizer on dado_serial (one extra cycle of latency).
module rx_serial_8n1 #(
   parameter int unsigned CICLOS_POR_BIT = 5208
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dado_serial,
   input  logic       recebe_dado,
   output logic [7:0] dados_ascii,
   output logic       pronto,
   output logic       tem_dado,
   output logic       erro_stop,
   output logic       sobrescrita,
   output logic       ocupado
);

   localparam int unsigned METADE = CICLOS_POR_BIT / 2;
   localparam int unsigned CW     = $clog2(CICLOS_POR_BIT);
   localparam logic [CW-1:0] ULTIMO_BIT    = CW'(CICLOS_POR_BIT - 1);
   localparam logic [CW-1:0] ULTIMO_METADE = CW'(METADE - 1);

   localparam logic [2:0] OCIOSO = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DADOS  = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] FIM    = 3'd4;
   localparam logic [2:0] ESPERA = 3'd5;

   logic          linha_s;
   logic [2:0]    estado;
   logic [2:0]    estado_prox;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          stop_s;
   logic          fim_meio;
   logic          fim_bit;

   // Reset holds the line register at the idle level so no phantom start is seen.
`ifdef RX_SYNC2_EN
   logic linha_meta;
   always_ff @(posedge clock) begin
      if (reset) begin
         linha_meta <= 1'b1;
         linha_s    <= 1'b1;
      end else begin
         linha_meta <= dado_serial;
         linha_s    <= linha_meta;
      end
   end
`else
   always_ff @(posedge clock) begin
      if (reset) linha_s <= 1'b1;
      else       linha_s <= dado_serial;
   end
`endif

   assign fim_meio = (cnt == ULTIMO_METADE);
   assign fim_bit  = (cnt == ULTIMO_BIT);

   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO: if (!linha_s) estado_prox = START;
         START:  if (fim_meio) estado_prox = linha_s ? OCIOSO : DADOS;
         DADOS:  if (fim_bit && idx == 3'd7) estado_prox = STOP;
         STOP:   if (fim_bit) estado_prox = FIM;
         FIM:    estado_prox = stop_s ? OCIOSO : ESPERA;
         ESPERA: if (linha_s) estado_prox = OCIOSO;
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado  <= OCIOSO;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         stop_s  <= 1'b0;
         ocupado <= 1'b0;
      end else begin
         estado  <= estado_prox;
         ocupado <= (estado_prox != OCIOSO);
         case (estado)
            START: begin
               if (fim_meio) begin
                  cnt <= '0;
                  idx <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DADOS: begin
               if (fim_bit) begin
                  cnt   <= '0;
                  idx   <= idx + 3'd1;
                  shreg <= {linha_s, shreg[7:1]};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (fim_bit) begin
                  cnt    <= '0;
                  stop_s <= linha_s;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   // A completing frame takes priority over an acknowledge in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         dados_ascii <= '0;
         pronto      <= 1'b0;
         tem_dado    <= 1'b0;
         erro_stop   <= 1'b0;
         sobrescrita <= 1'b0;
      end else begin
         pronto <= 1'b0;
         if (estado == FIM) begin
            dados_ascii <= shreg;
            pronto      <= 1'b1;
            tem_dado    <= 1'b1;
            erro_stop   <= ~stop_s;
            if (tem_dado && !recebe_dado) sobrescrita <= 1'b1;
         end else if (recebe_dado) begin
            tem_dado    <= 1'b0;
            sobrescrita <= 1'b0;
         end
      end
   end

endmodule
